// File: rtl/sccb_pkg.sv
// ---------------------------------------------------------------------------
// sccb_pkg
// Shared definitions for the SCCB write master: controller state encoding,
// quarter-phase encoding within one SCL period, the default write ID, the
// number of bytes in one register write, and a helper that maps
// (state, quarter, data bit) onto the SCL level and the SDA pull-down enable.
// ---------------------------------------------------------------------------
package sccb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } sccb_state_t;

    typedef enum logic [1:0] {
        QTR_0,
        QTR_1,
        QTR_2,
        QTR_3
    } qtr_phase_t;

    localparam logic [7:0] DEFAULT_DEV_ADDR = 8'h78;
    localparam int         BYTES_PER_WRITE  = 4;

    // Returns {scl, sda_oe}. sda_oe=1 pulls SDA low, 0 releases it.
    // SDA only moves while SCL is low, except for the deliberate falling
    // edge in START q1 and rising edge in STOP q2.
    function automatic logic [1:0] line_levels(input sccb_state_t st,
                                               input qtr_phase_t  q,
                                               input logic        tx_bit);
        logic [1:0] lv;
        lv = 2'b10;
        case (st)
            ST_START: begin
                case (q)
                    QTR_0:   lv = 2'b10;
                    QTR_1:   lv = 2'b11;
                    default: lv = 2'b01;
                endcase
            end
            ST_BIT:  lv = {(q == QTR_1) || (q == QTR_2), ~tx_bit};
            ST_ACK:  lv = {(q == QTR_1) || (q == QTR_2), 1'b0};
            ST_STOP: begin
                case (q)
                    QTR_0:   lv = 2'b01;
                    QTR_1:   lv = 2'b11;
                    default: lv = 2'b10;
                endcase
            end
            default: lv = 2'b10;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/sccb_qtr_tick.sv
// ---------------------------------------------------------------------------
// sccb_qtr_tick
// Quarter-period divider. Counts sys_clk cycles while enabled and pulses
// tick in the last cycle of every QTR_DIV-cycle quarter.
// Ports:
//   sys_clk  - system clock
//   sys_rst  - synchronous active-high reset
//   restart  - forces the count back to 0 so a new quarter starts next cycle
//   enable   - counts only while high
//   tick     - one-cycle pulse in the final cycle of each quarter
// ---------------------------------------------------------------------------
module sccb_qtr_tick #(
    parameter logic [15:0] QTR_DIV = 16'd125
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    logic [15:0] cnt;
    logic        at_last;

    assign at_last = (cnt == QTR_DIV - 16'd1);
    assign tick    = enable && at_last;

    // Free-running modulo-QTR_DIV counter; restart has priority so the
    // first quarter of a transfer is always a full QTR_DIV cycles long.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || restart) begin
            cnt <= 16'd0;
        end else if (enable) begin
            cnt <= at_last ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/sccb_wr_master.sv
// ---------------------------------------------------------------------------
// sccb_wr_master
// Single-register SCCB (I2C-style) write master: START, DEV_ADDR, three data
// bytes {reg_addr_hi, reg_addr_lo, reg_val} each followed by an ACK slot,
// then STOP. A NAK only sets the sticky ack_err flag; the write still runs
// to completion.
// Ports:
//   sys_clk   - system clock
//   sys_rst   - synchronous active-high reset (aborts without STOP)
//   cfg_start - one-cycle write request, honoured only when idle
//   cfg_data  - {reg_addr[15:0], reg_val[7:0]}, latched on acceptance
//   cfg_end   - one-cycle pulse when the write completes
//   busy      - high from the cycle after acceptance through cfg_end
//   ack_err   - sticky: an ACK slot of the current/last write read SDA high
//   scl       - SCCB clock (push-pull)
//   sda_oe    - 1 pulls SDA low, 0 releases it
//   sda_i     - sampled SDA line
// ---------------------------------------------------------------------------
module sccb_wr_master
    import sccb_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR = DEFAULT_DEV_ADDR,
    parameter logic [15:0] QTR_DIV  = 16'd125
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_start,
    input  logic [23:0] cfg_data,
    output logic        cfg_end,
    output logic        busy,
    output logic        ack_err,
    output logic        scl,
    output logic        sda_oe,
    input  logic        sda_i
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WRITE - 1);

    sccb_state_t state, nxt_state;
    qtr_phase_t  qtr, nxt_qtr;
    logic [2:0]  bit_idx, nxt_bit_idx;
    logic [1:0]  byte_idx, nxt_byte_idx;
    logic [23:0] data_q;
    logic [7:0]  nxt_byte;
    logic        nxt_tx_bit;
    logic        accept;
    logic        tick;

    assign accept = (state == ST_IDLE) && cfg_start;

    sccb_qtr_tick #(
        .QTR_DIV (QTR_DIV)
    ) u_qtr_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .restart (accept),
        .enable  (state != ST_IDLE),
        .tick    (tick)
    );

    // Next-state logic. Every non-idle state walks q0..q3 on ticks; the bit
    // and byte indices wrap naturally so no explicit clears are needed when
    // moving between BIT and ACK.
    always_comb begin
        nxt_state    = state;
        nxt_qtr      = qtr;
        nxt_bit_idx  = bit_idx;
        nxt_byte_idx = byte_idx;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    nxt_state    = ST_START;
                    nxt_qtr      = QTR_0;
                    nxt_bit_idx  = 3'd0;
                    nxt_byte_idx = 2'd0;
                end
            end
            ST_START: begin
                if (tick) begin
                    nxt_qtr = qtr_phase_t'(qtr + 2'd1);
                    if (qtr == QTR_3) nxt_state = ST_BIT;
                end
            end
            ST_BIT: begin
                if (tick) begin
                    nxt_qtr = qtr_phase_t'(qtr + 2'd1);
                    if (qtr == QTR_3) begin
                        nxt_bit_idx = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) nxt_state = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    nxt_qtr = qtr_phase_t'(qtr + 2'd1);
                    if (qtr == QTR_3) begin
                        if (byte_idx == LAST_BYTE) begin
                            nxt_state = ST_STOP;
                        end else begin
                            nxt_state    = ST_BIT;
                            nxt_byte_idx = byte_idx + 2'd1;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    nxt_qtr = qtr_phase_t'(qtr + 2'd1);
                    if (qtr == QTR_3) nxt_state = ST_DONE;
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
                nxt_qtr   = QTR_0;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Byte and bit that will be on the wire next cycle, MSB first.
    always_comb begin
        case (nxt_byte_idx)
            2'd0:    nxt_byte = DEV_ADDR;
            2'd1:    nxt_byte = data_q[23:16];
            2'd2:    nxt_byte = data_q[15:8];
            default: nxt_byte = data_q[7:0];
        endcase
        nxt_tx_bit = nxt_byte[3'd7 - nxt_bit_idx];
    end

    // State register plus registered bus/handshake outputs. Outputs are
    // derived from the next state so they line up with the state they
    // belong to. ack_err samples SDA in the final cycle of ACK q2.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            qtr      <= QTR_0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            data_q   <= 24'd0;
            cfg_end  <= 1'b0;
            busy     <= 1'b0;
            ack_err  <= 1'b0;
            scl      <= 1'b1;
            sda_oe   <= 1'b0;
        end else begin
            state    <= nxt_state;
            qtr      <= nxt_qtr;
            bit_idx  <= nxt_bit_idx;
            byte_idx <= nxt_byte_idx;
            if (accept) data_q <= cfg_data;
            cfg_end  <= (nxt_state == ST_DONE);
            busy     <= (nxt_state != ST_IDLE);
            {scl, sda_oe} <= line_levels(nxt_state, nxt_qtr, nxt_tx_bit);
            if (accept) begin
                ack_err <= 1'b0;
            end else if ((state == ST_ACK) && (qtr == QTR_2) && tick && sda_i) begin
                ack_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sccb_wr_master.sv
// ---------------------------------------------------------------------------
// tb_sccb_wr_master
// Self-checking bench for sccb_wr_master. A protocol-level bus monitor
// decodes bytes from SCL/SDA, acts as the responder (ACK or NAK per byte),
// and counts SDA edges during SCL high that are not a START or STOP.
// Expected values come from the write rules: byte order, 152 quarters plus
// one cycle of latency, and ack_err = any NAK in the write.
// ---------------------------------------------------------------------------
module tb_sccb_wr_master;

    localparam logic [15:0] QTR_A    = 16'd4;
    localparam logic [15:0] QTR_B    = 16'd2;
    localparam logic [7:0]  TB_DEV   = 8'h78;
    localparam int          N_BYTES  = 4;
    localparam int          N_B2B    = 64;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cfg_start;
    logic        cfg_start2;
    logic [23:0] cfg_data;
    logic        cfg_end, busy, ack_err, scl, sda_oe;
    logic        cfg_end2, busy2, ack_err2, scl2, sda_oe2;
    logic        sda_line;
    logic        sda_line2;
    logic        resp_pull = 1'b0;
    logic [3:0]  nak_mask = 4'd0;

    int          cyc = 0;
    int          t0 = 0;
    int          checks = 0;
    int          failures = 0;
    int          end_count = 0;
    int          illegal_edges = 0;

    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        in_frame = 1'b0;
    int          bitcnt = 0;
    int          frame_byte = 0;
    logic [7:0]  shreg = 8'd0;
    logic [7:0]  mon_bytes[$];

    assign sda_line  = ~(sda_oe | resp_pull);
    assign sda_line2 = ~sda_oe2;

    sccb_wr_master #(
        .DEV_ADDR (TB_DEV),
        .QTR_DIV  (QTR_A)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cfg_start (cfg_start),
        .cfg_data  (cfg_data),
        .cfg_end   (cfg_end),
        .busy      (busy),
        .ack_err   (ack_err),
        .scl       (scl),
        .sda_oe    (sda_oe),
        .sda_i     (sda_line)
    );

    sccb_wr_master #(
        .DEV_ADDR (TB_DEV),
        .QTR_DIV  (QTR_B)
    ) dut2 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cfg_start (cfg_start2),
        .cfg_data  (cfg_data),
        .cfg_end   (cfg_end2),
        .busy      (busy2),
        .ack_err   (ack_err2),
        .scl       (scl2),
        .sda_oe    (sda_oe2),
        .sda_i     (sda_line2)
    );

    // 10 ns system clock.
    always #5 sys_clk = ~sys_clk;

    // Cycle counter used to measure request-to-completion latency.
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Bus monitor and responder. Data is captured on SCL rising edges; the
    // ninth rising edge of a byte is the ACK slot. The responder pulls SDA
    // low from the eighth falling edge to the ninth unless that byte is
    // marked for NAK. Any SDA change during SCL high that is not an idle
    // START or a STOP right after an ACK counts as illegal.
    always @(negedge sys_clk) begin
        prev_scl <= scl;
        prev_sda <= sda_line;
        if (cfg_end === 1'b1) end_count <= end_count + 1;
        if (busy !== 1'b1) begin
            in_frame   <= 1'b0;
            bitcnt     <= 0;
            frame_byte <= 0;
            resp_pull  <= 1'b0;
        end else if (prev_scl && scl && (prev_sda != sda_line)) begin
            if (!sda_line) begin
                if (in_frame) illegal_edges <= illegal_edges + 1;
                in_frame   <= 1'b1;
                bitcnt     <= 0;
                frame_byte <= 0;
            end else begin
                if (!(in_frame && bitcnt == 1)) illegal_edges <= illegal_edges + 1;
                in_frame <= 1'b0;
                bitcnt   <= 0;
            end
        end else if (in_frame && !prev_scl && scl) begin
            if (bitcnt < 8) begin
                shreg  <= {shreg[6:0], sda_line};
                bitcnt <= bitcnt + 1;
            end else begin
                mon_bytes.push_back(shreg);
                bitcnt     <= 9;
                frame_byte <= frame_byte + 1;
            end
        end else if (in_frame && prev_scl && !scl) begin
            if (bitcnt == 8) begin
                resp_pull <= (frame_byte < N_BYTES) ? !nak_mask[frame_byte] : 1'b0;
            end else if (bitcnt == 9) begin
                resp_pull <= 1'b0;
                bitcnt    <= 0;
            end
        end
    end

    function automatic int expLatency(input int qtr_div);
        return (4 + N_BYTES * 9 * 4 + 4) * qtr_div + 1;
    endfunction

    function automatic logic [7:0] expByte(input int idx, input logic [23:0] d);
        case (idx)
            0:       return TB_DEV;
            1:       return d[23:16];
            2:       return d[15:8];
            default: return d[7:0];
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issues a request at the current negedge and returns one cycle later.
    task automatic applyStimulus(input logic [23:0] data, input logic [3:0] nak);
        nak_mask = nak;
        mon_bytes.delete();
        cfg_data  = data;
        cfg_start = 1'b1;
        t0        = cyc;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        cfg_data  = 24'($urandom);
    endtask

    // Waits (bounded) for cfg_end and checks latency, handshake and bytes.
    task automatic checkWrite(input string tag, input logic [23:0] data,
                              input logic [3:0] nak);
        int          lat;
        logic [31:0] obs;
        lat = -1;
        for (int i = 0; i < 4000; i++) begin
            if (cfg_end === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            @(negedge sys_clk);
        end
        checkOutput($sformatf("%s_latency", tag), lat, expLatency(int'(QTR_A)));
        checkOutput($sformatf("%s_busy_at_end", tag), busy, 1'b1);
        checkOutput($sformatf("%s_ack_err", tag), ack_err, |nak);
        checkOutput($sformatf("%s_nbytes", tag), mon_bytes.size(), N_BYTES);
        for (int i = 0; i < N_BYTES; i++) begin
            obs = (i < mon_bytes.size()) ? {24'd0, mon_bytes[i]} : 32'hFFFF_FFFF;
            checkOutput($sformatf("%s_byte%0d", tag, i), obs, expByte(i, data));
        end
    endtask

    task automatic checkTail(input string tag);
        @(negedge sys_clk);
        checkOutput($sformatf("%s_end_pulse", tag), cfg_end, 1'b0);
        checkOutput($sformatf("%s_busy_after", tag), busy, 1'b0);
        checkOutput($sformatf("%s_scl_idle", tag), scl, 1'b1);
    endtask

    // Directed sequence of scenarios with randomised payloads.
    initial begin
        logic [23:0] d1, d2;
        logic [3:0]  nk;
        int          ends_seen, ends_base, lat2;

        sys_rst    = 1'b1;
        cfg_start  = 1'b0;
        cfg_start2 = 1'b0;
        cfg_data   = 24'd0;
        repeat (3) @(negedge sys_clk);

        checkOutput("rst_scl", scl, 1'b1);
        checkOutput("rst_sda_oe", sda_oe, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_cfg_end", cfg_end, 1'b0);
        checkOutput("rst_ack_err", ack_err, 1'b0);
        checkOutput("rst_scl2", scl2, 1'b1);
        checkOutput("rst_busy2", busy2, 1'b0);

        $display("[TB] basic write, all ACK");
        sys_rst = 1'b0;
        applyStimulus(24'h300882, 4'b0000);
        checkOutput("basic_busy_k1", busy, 1'b1);
        checkWrite("basic", 24'h300882, 4'b0000);
        checkTail("basic");

        $display("[TB] NAK on third byte");
        d1 = 24'($urandom);
        applyStimulus(d1, 4'b0100);
        checkWrite("nak3", d1, 4'b0100);
        checkTail("nak3");
        checkOutput("nak3_ack_err_held", ack_err, 1'b1);
        d1 = 24'($urandom);
        applyStimulus(d1, 4'b0000);
        checkOutput("ack_err_cleared", ack_err, 1'b0);
        checkWrite("after_nak", d1, 4'b0000);
        checkTail("after_nak");

        $display("[TB] cfg_start while busy");
        d1 = 24'($urandom);
        d2 = ~d1;
        applyStimulus(d1, 4'b0000);
        repeat (49) @(negedge sys_clk);
        cfg_data  = d2;
        cfg_start = 1'b1;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        checkWrite("busy_ignore", d1, 4'b0000);

        $display("[TB] cfg_start coinciding with cfg_end");
        cfg_start = 1'b1;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        checkOutput("done_start_busy1", busy, 1'b0);
        @(negedge sys_clk);
        checkOutput("done_start_busy2", busy, 1'b0);
        checkOutput("done_start_scl", scl, 1'b1);

        $display("[TB] reset mid-transfer");
        d1 = 24'($urandom);
        applyStimulus(d1, 4'b0000);
        repeat (199) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        checkOutput("midrst_scl", scl, 1'b1);
        checkOutput("midrst_sda_oe", sda_oe, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        sys_rst   = 1'b0;
        ends_seen = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge sys_clk);
            if (cfg_end === 1'b1 || busy === 1'b1) ends_seen++;
        end
        checkOutput("midrst_no_end", ends_seen, 0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        d1 = 24'($urandom);
        applyStimulus(d1, 4'b0000);
        checkWrite("post_rst", d1, 4'b0000);
        checkTail("post_rst");

        $display("[TB] back-to-back writes");
        illegal_edges = 0;
        ends_base = end_count;
        for (int n = 0; n < N_B2B; n++) begin
            d1 = 24'($urandom);
            nk = 4'($urandom);
            applyStimulus(d1, nk);
            checkWrite($sformatf("b2b%0d", n), d1, nk);
            @(negedge sys_clk);
        end
        @(negedge sys_clk);
        checkOutput("b2b_end_pulses", end_count - ends_base, N_B2B);
        checkOutput("b2b_illegal_sda_edges", illegal_edges, 0);

        $display("[TB] QTR_DIV=2 latency");
        cfg_data   = 24'($urandom);
        cfg_start2 = 1'b1;
        t0         = cyc;
        @(negedge sys_clk);
        cfg_start2 = 1'b0;
        lat2 = -1;
        for (int i = 0; i < 1000; i++) begin
            if (cfg_end2 === 1'b1) begin
                lat2 = cyc - t0;
                break;
            end
            @(negedge sys_clk);
        end
        checkOutput("q2_latency", lat2, expLatency(int'(QTR_B)));
        checkOutput("q2_ack_err_no_responder", ack_err2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
